// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the program-counter controller: FSM state encoding
// and the default address map used when the block is instantiated bare.
package pc_ctrl_pkg;

  // Controller states. BOOT is the single post-reset settling cycle, RUN is
  // normal sequential/redirected fetch, FAULT parks on an illegal address.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Default address map (32-bit). The top module resizes these to WIDTH.
  localparam logic [31:0] DEF_RESET_ADDR = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] DEF_IMEM_BASE  = 32'h0000_3000;
  localparam int          DEF_IMEM_DEPTH = 4096;

  // Increment applied on sequential fetch, one 32-bit instruction word.
  localparam int          FETCH_STEP     = 4;

endpackage : pc_ctrl_pkg

// File: rtl/pc_ctrl_range_chk.sv
// Combinational fetch-address legality check: an address is legal when it is
// word aligned and lies inside the instruction memory window
// [IMEM_BASE, IMEM_BASE + 4*IMEM_DEPTH - 4].
module pc_range_chk
  import pc_ctrl_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] IMEM_BASE  = WIDTH'(DEF_IMEM_BASE),
  parameter int               IMEM_DEPTH = DEF_IMEM_DEPTH
) (
  input  logic [WIDTH-1:0] addr,
  output logic             legal
);

  // The window bounds are evaluated two bits wider than the address so that
  // a window touching the top of the address space cannot overflow and
  // silently wrap the upper bound below the lower one.
  localparam logic [WIDTH+1:0] LO_ADDR = {2'b00, IMEM_BASE};
  localparam logic [WIDTH+1:0] SPAN    = (WIDTH+2)'(IMEM_DEPTH) << 2;
  localparam logic [WIDTH+1:0] HI_ADDR = LO_ADDR + SPAN - (WIDTH+2)'(4);

  logic [WIDTH+1:0] addr_ext;
  logic             aligned;
  logic             in_range;

  assign addr_ext = {2'b00, addr};

  // Alignment and inclusive range comparison combine into the legal flag.
  always_comb begin
    aligned  = (addr[1:0] == 2'b00);
    in_range = (addr_ext >= LO_ADDR) && (addr_ext <= HI_ADDR);
    legal    = aligned && in_range;
  end

endmodule : pc_range_chk

// File: rtl/pc_ctrl.sv
// Program-counter controller. Chooses the next fetch address from exception
// entry, exception return, stall, branch redirect and sequential increment,
// tracks whether the current PC is legal, and keeps the exception return
// address (epc).
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(DEF_RESET_ADDR),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR),
  parameter logic [WIDTH-1:0] IMEM_BASE  = WIDTH'(DEF_IMEM_BASE),
  parameter int               IMEM_DEPTH = DEF_IMEM_DEPTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  input  logic [WIDTH-1:0] exc_epc,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic             fault,
  output logic [WIDTH-1:0] epc
);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] next_epc;
  logic [WIDTH-1:0] candidate;
  logic [WIDTH-1:0] pc_plus4;
  logic             cand_legal;
  logic             epc_legal;

  // Sequential fetch address; wraps modulo 2^WIDTH and is then judged by
  // the range checker like any other candidate.
  assign pc_plus4 = pc + WIDTH'(FETCH_STEP);

  // Candidate next PC in strict priority order: exception entry, exception
  // return, stall hold, branch redirect, sequential increment.
  always_comb begin
    candidate = pc_plus4;
    if (exc_req) begin
      candidate = EXC_VECTOR;
    end else if (eret) begin
      candidate = epc;
    end else if (stall) begin
      candidate = pc;
    end else if (br_valid) begin
      candidate = br_target;
    end
  end

  pc_range_chk #(
    .WIDTH      (WIDTH),
    .IMEM_BASE  (IMEM_BASE),
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_cand_chk (
    .addr  (candidate),
    .legal (cand_legal)
  );

  pc_range_chk #(
    .WIDTH      (WIDTH),
    .IMEM_BASE  (IMEM_BASE),
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_epc_chk (
    .addr  (epc),
    .legal (epc_legal)
  );

  // Next-state decode. BOOT ignores every input for its single cycle. In
  // RUN the candidate is always loaded and its legality picks RUN or FAULT;
  // a stalled RUN cycle reloads the already-legal pc and never re-faults.
  // FAULT holds pc and only leaves on exception entry or exception return.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    next_epc   = epc;
    case (state)
      BOOT: begin
        next_state = RUN;
      end
      RUN: begin
        next_pc = candidate;
        if (exc_req) begin
          next_epc = exc_epc;
        end
        if (!exc_req && !eret && stall) begin
          next_state = RUN;
        end else if (cand_legal) begin
          next_state = RUN;
        end else begin
          next_state = FAULT;
        end
      end
      FAULT: begin
        if (exc_req) begin
          next_pc    = EXC_VECTOR;
          next_epc   = exc_epc;
          next_state = RUN;
        end else if (eret) begin
          next_pc    = epc;
          next_state = epc_legal ? RUN : FAULT;
        end
      end
      default: begin
        next_state = BOOT;
        next_pc    = RESET_ADDR;
      end
    endcase
  end

  // State, pc and epc registers; reset forces BOOT at the reset address
  // with a cleared epc regardless of the clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= BOOT;
      pc    <= RESET_ADDR;
      epc   <= '0;
    end else begin
      state <= next_state;
      pc    <= next_pc;
      epc   <= next_epc;
    end
  end

  // Output flags decode directly from the state, so they are mutually
  // exclusive by construction.
  always_comb begin
    pc_valid = (state == RUN);
    fault    = (state == FAULT);
  end

endmodule : pc_ctrl

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl with hand-computed expectations.
module tb_pc_ctrl;

   logic        clk;
   logic        reset_n;
   logic        stall;
   logic        br_valid;
   logic [31:0] br_target;
   logic        exc_req;
   logic [31:0] exc_epc;
   logic        eret;
   logic [31:0] pc;
   logic        pc_valid;
   logic        fault;
   logic [31:0] epc;

   int errors;
   int checks;

   pc_ctrl dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .stall     (stall),
      .br_valid  (br_valid),
      .br_target (br_target),
      .exc_req   (exc_req),
      .exc_epc   (exc_epc),
      .eret      (eret),
      .pc        (pc),
      .pc_valid  (pc_valid),
      .fault     (fault),
      .epc       (epc)
   );

   // Compares one observed value against its expectation and logs failures.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expected);
      checks++;
      if (obs !== expected) begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expected);
      end
   endtask

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Directed sequence: inputs change and outputs are sampled on the falling
   // edge, so every rising edge sees stable stimulus.
   initial begin
      errors    = 0;
      checks    = 0;
      reset_n   = 1'b0;
      stall     = 1'b0;
      br_valid  = 1'b0;
      br_target = 32'h0;
      exc_req   = 1'b0;
      exc_epc   = 32'h0;
      eret      = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_pc",    pc,       32'h3000);
      checkOutput("reset_valid", pc_valid, 1'b0);
      checkOutput("reset_fault", fault,    1'b0);
      checkOutput("reset_epc",   epc,      32'h0);

      // Release reset with inputs that BOOT must ignore.
      reset_n   = 1'b1;
      br_valid  = 1'b1;
      br_target = 32'h3100;
      exc_req   = 1'b1;
      exc_epc   = 32'h1234;
      #1;
      checkOutput("boot_pc",    pc,       32'h3000);
      checkOutput("boot_valid", pc_valid, 1'b0);

      @(negedge clk);
      checkOutput("run0_pc",    pc,       32'h3000);
      checkOutput("run0_valid", pc_valid, 1'b1);
      checkOutput("run0_epc",   epc,      32'h0);
      br_valid = 1'b0;
      exc_req  = 1'b0;

      @(negedge clk);
      checkOutput("seq1_pc", pc, 32'h3004);
      @(negedge clk);
      checkOutput("seq2_pc", pc, 32'h3008);

      // Stall outranks branch for two cycles, then the branch lands.
      stall     = 1'b1;
      br_valid  = 1'b1;
      br_target = 32'h3100;
      @(negedge clk);
      checkOutput("stall1_pc",    pc,       32'h3008);
      checkOutput("stall1_valid", pc_valid, 1'b1);
      @(negedge clk);
      checkOutput("stall2_pc", pc, 32'h3008);
      stall = 1'b0;
      @(negedge clk);
      checkOutput("branch_pc", pc, 32'h3100);
      br_valid = 1'b0;

      // Exception entry wins over a simultaneous eret.
      exc_req = 1'b1;
      exc_epc = 32'h3010;
      eret    = 1'b1;
      @(negedge clk);
      checkOutput("exc_pc",    pc,       32'h4180);
      checkOutput("exc_epc",   epc,      32'h3010);
      checkOutput("exc_valid", pc_valid, 1'b1);
      exc_req = 1'b0;
      @(negedge clk);
      checkOutput("eret_pc",    pc,       32'h3010);
      checkOutput("eret_valid", pc_valid, 1'b1);
      eret = 1'b0;

      // Misaligned branch target faults and is held through stall and branch.
      br_valid  = 1'b1;
      br_target = 32'h3102;
      @(negedge clk);
      checkOutput("misal_pc",    pc,       32'h3102);
      checkOutput("misal_fault", fault,    1'b1);
      checkOutput("misal_valid", pc_valid, 1'b0);
      br_target = 32'h3200;
      stall     = 1'b1;
      @(negedge clk);
      checkOutput("fhold_stall_pc",    pc,    32'h3102);
      checkOutput("fhold_stall_fault", fault, 1'b1);
      stall = 1'b0;
      @(negedge clk);
      checkOutput("fhold_br_pc",    pc,    32'h3102);
      checkOutput("fhold_br_fault", fault, 1'b1);
      br_valid = 1'b0;

      // Exception leaves FAULT; save an out-of-range return address.
      exc_req = 1'b1;
      exc_epc = 32'h7000;
      @(negedge clk);
      checkOutput("fexc_pc",    pc,       32'h4180);
      checkOutput("fexc_valid", pc_valid, 1'b1);
      checkOutput("fexc_fault", fault,    1'b0);
      checkOutput("fexc_epc",   epc,      32'h7000);
      exc_req = 1'b0;

      // eret to an illegal epc faults from RUN, and stays faulted from FAULT.
      eret = 1'b1;
      @(negedge clk);
      checkOutput("eret_bad_pc",    pc,    32'h7000);
      checkOutput("eret_bad_fault", fault, 1'b1);
      @(negedge clk);
      checkOutput("feret_bad_pc",    pc,    32'h7000);
      checkOutput("feret_bad_fault", fault, 1'b1);
      eret = 1'b0;

      exc_req = 1'b1;
      exc_epc = 32'h3020;
      @(negedge clk);
      checkOutput("fexc2_pc",  pc,       32'h4180);
      checkOutput("fexc2_epc", epc,      32'h3020);
      checkOutput("fexc2_run", pc_valid, 1'b1);
      exc_req = 1'b0;

      // Last legal word, then sequential run off the top of the window.
      br_valid  = 1'b1;
      br_target = 32'h6FFC;
      @(negedge clk);
      checkOutput("top_pc",    pc,       32'h6FFC);
      checkOutput("top_valid", pc_valid, 1'b1);
      br_valid = 1'b0;
      @(negedge clk);
      checkOutput("over_pc",    pc,       32'h7000);
      checkOutput("over_fault", fault,    1'b1);
      checkOutput("over_valid", pc_valid, 1'b0);

      // eret from FAULT with a legal epc returns to RUN.
      eret = 1'b1;
      @(negedge clk);
      checkOutput("feret_ok_pc",    pc,       32'h3020);
      checkOutput("feret_ok_valid", pc_valid, 1'b1);
      eret = 1'b0;

      // Below the window faults.
      br_valid  = 1'b1;
      br_target = 32'h2FFC;
      @(negedge clk);
      checkOutput("under_pc",    pc,    32'h2FFC);
      checkOutput("under_fault", fault, 1'b1);
      br_valid = 1'b0;

      // Asynchronous reset between clock edges while in FAULT.
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("areset_pc",    pc,       32'h3000);
      checkOutput("areset_fault", fault,    1'b0);
      checkOutput("areset_valid", pc_valid, 1'b0);
      checkOutput("areset_epc",   epc,      32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("rerun_pc",    pc,       32'h3000);
      checkOutput("rerun_valid", pc_valid, 1'b1);
      @(negedge clk);
      checkOutput("rerun_seq_pc", pc, 32'h3004);

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_pc_ctrl
